// File: rtl/mac_vlg_tx_arb_if.sv
// Handshake and data bundle between the frame sources, the TX arbiter and the MAC.
// master = arbiter side, slave = sources plus MAC side.
interface mac_vlg_tx_arb_if #(
  parameter int N = 4
);
  logic [N-1:0]       src_rdy;
  logic [N-1:0][15:0] src_len;
  logic [N-1:0][47:0] src_dst;
  logic [N-1:0][15:0] src_etype;
  logic [N-1:0][7:0]  src_dat;
  logic [N-1:0]       src_acc;
  logic [N-1:0]       src_req;
  logic [N-1:0]       src_done;
  logic               mac_rdy;
  logic [15:0]        mac_len;
  logic [47:0]        mac_dst;
  logic [15:0]        mac_etype;
  logic [7:0]         mac_dat;
  logic               mac_acc;
  logic               mac_req;
  logic               mac_done;

  // Handshakes: src_rdy[i] stays high until the cycle src_acc[i] pulses. mac_rdy stays
  // high until mac_acc; the cycle with both high hands the frame to the MAC and src_acc
  // echoes it. One payload byte moves in every granted cycle with mac_req high
  // (src_req mirrors it, mac_dat returns the byte). mac_done closes the frame.
  modport master (
    input  src_rdy, src_len, src_dst, src_etype, src_dat,
    output src_acc, src_req, src_done,
    output mac_rdy, mac_len, mac_dst, mac_etype, mac_dat,
    input  mac_acc, mac_req, mac_done
  );

  modport slave (
    output src_rdy, src_len, src_dst, src_etype, src_dat,
    input  src_acc, src_req, src_done,
    input  mac_rdy, mac_len, mac_dst, mac_etype, mac_dat,
    output mac_acc, mac_req, mac_done
  );
endinterface

// File: rtl/mac_vlg_tx_arb.sv
// Round-robin arbiter sharing the MAC TX path among N frame sources, with watchdog.
// Define MAC_VLG_TX_ARB_IFG_EN to insert IFG_LEN idle cycles after every completed frame.
module mac_vlg_tx_arb #(
  parameter int N       = 4,
  parameter int IFG_LEN = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_vlg_tx_arb_if.master     bus,
  output logic [$clog2(N)-1:0] grant,
  output logic                 busy,
  output logic                 err_tmo,
  output logic [1:0]           state_dbg
);
  localparam int GW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OFFER  = 2'd1,
    S_ACTIVE = 2'd2
`ifdef MAC_VLG_TX_ARB_IFG_EN
    , S_GAP  = 2'd3
`endif
  } state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grant_nx;
  logic [GW-1:0] rr_ptr, rr_ptr_nx;
  logic [GW-1:0] pick;
  logic [GW-1:0] grant_inc;
  logic [15:0]   cnt, cnt_nx;
  logic          found;
  logic          tmo_hit;

  // Out-of-range parameters show up as this block in the elaborated hierarchy.
  if (N < 2 || N > 8 || IFG_LEN < 1 || IFG_LEN > 65535 || TIMEOUT < 2 || TIMEOUT > 65536)
  begin : g_param_out_of_range
  end

  // First requesting source at or after the pointer, wrapping modulo N.
  always_comb begin : rr_pick
    int idx;
    found = 1'b0;
    pick  = rr_ptr;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!found && bus.src_rdy[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign grant_inc = (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
  // One counter serves as frame watchdog in OFFER/ACTIVE and as gap timer in GAP.
  assign tmo_hit   = (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_ptr_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    rr_ptr_nx    = rr_ptr;
    cnt_nx       = cnt;
    bus.src_acc  = '0;
    bus.src_req  = '0;
    bus.src_done = '0;
    bus.mac_rdy  = 1'b0;
    err_tmo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nx = pick;
          cnt_nx   = '0;
          state_nx = S_OFFER;
        end
      end
      S_OFFER: begin
        bus.mac_rdy = 1'b1;
        cnt_nx      = cnt + 16'd1;
        // An expiring offer is withdrawn even if the MAC accepts in the same cycle.
        if (tmo_hit) begin
          err_tmo   = 1'b1;
          rr_ptr_nx = grant_inc;
          state_nx  = S_IDLE;
        end else if (bus.mac_acc) begin
          bus.src_acc[grant] = 1'b1;
          state_nx           = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        cnt_nx             = cnt + 16'd1;
        bus.src_req[grant] = bus.mac_req;
        // A frame the MAC completes counts as done even on the watchdog's last cycle.
        if (bus.mac_done) begin
          bus.src_done[grant] = 1'b1;
          rr_ptr_nx           = grant_inc;
`ifdef MAC_VLG_TX_ARB_IFG_EN
          cnt_nx              = '0;
          state_nx            = S_GAP;
`else
          state_nx            = S_IDLE;
`endif
        end else if (tmo_hit) begin
          err_tmo   = 1'b1;
          rr_ptr_nx = grant_inc;
          state_nx  = S_IDLE;
        end
      end
`ifdef MAC_VLG_TX_ARB_IFG_EN
      S_GAP: begin
        cnt_nx = cnt + 16'd1;
        if (cnt == 16'(IFG_LEN - 1)) begin
          state_nx = S_IDLE;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.mac_len   = bus.src_len[grant];
  assign bus.mac_dst   = bus.src_dst[grant];
  assign bus.mac_etype = bus.src_etype[grant];
  assign bus.mac_dat   = bus.src_dat[grant];
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;
endmodule

// File: tb/tb_mac_vlg_tx_arb.sv
// Randomized scoreboard bench for mac_vlg_tx_arb: a round-robin model predicts each offer,
// a monitor checks offers as they appear, the MAC-side driver checks the routed strobes.
module tb_mac_vlg_tx_arb;
  localparam int N       = 4;
  localparam int IFG_LEN = 12;
  localparam int TIMEOUT = 64;
`ifdef MAC_VLG_TX_ARB_IFG_EN
  localparam int GAP_CYC = IFG_LEN;
`else
  localparam int GAP_CYC = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_vlg_tx_arb_if #(.N(N)) bus ();
  logic [1:0] grant;
  logic       busy;
  logic       err_tmo;
  logic [1:0] state_dbg;

  mac_vlg_tx_arb #(.N(N), .IFG_LEN(IFG_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .grant     (grant),
    .busy      (busy),
    .err_tmo   (err_tmo),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] at;
    logic [1:0]  g;
    logic [15:0] len;
    logic [47:0] dst;
    logic [15:0] etype;
  } offer_t;
  localparam int OW = $bits(offer_t);

  logic [OW-1:0] exp_q[$];
  logic [N-1:0]  pend = '0;
  int            ptr_m = 0;
  int            cur_w = 0;
  int            g_at_acc = 0;
  logic [15:0]   len_m[N];
  logic [47:0]   dst_m[N];
  logic [15:0]   et_m[N];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: the first pending source at or after 'from', circularly.
  function automatic int rr_next(input logic [N-1:0] p, input int from);
    for (int k = 0; k < N; k++) begin
      if (p[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic push_expect(input int at);
    offer_t e;
    cur_w   = rr_next(pend, ptr_m);
    e.at    = 32'(at);
    e.g     = 2'(cur_w);
    e.len   = len_m[cur_w];
    e.dst   = dst_m[cur_w];
    e.etype = et_m[cur_w];
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_src(input int s, input int len);
    len_m[s] = (len > 0) ? 16'(len) : 16'($urandom_range(1, 12));
    dst_m[s] = {16'($urandom()), $urandom()};
    et_m[s]  = 16'($urandom());
    bus.src_len[s]   = len_m[s];
    bus.src_dst[s]   = dst_m[s];
    bus.src_etype[s] = et_m[s];
  endtask

  task automatic raise(input int s, input int len);
    load_src(s, len);
    bus.src_rdy[s] = 1'b1;
    pend[s]        = 1'b1;
  endtask

  // Called at a falling edge while the arbiter is idle: offer expected one cycle later.
  task automatic idle_raise(input logic [N-1:0] mask, input int len);
    for (int s = 0; s < N; s++) if (mask[s]) raise(s, len);
    if (pend != 0) push_expect(cyc + 1);
  endtask

  task automatic idle_wait();
    repeat (GAP_CYC + 2) @(negedge clk);
  endtask

  task automatic wait_offer(output bit ok);
    int t;
    t = 0;
    while (!bus.mac_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = bus.mac_rdy;
    if (!ok) check("offer_wait", 0, 1);
  endtask

  // MAC side of one frame: accept, pull the payload, signal done.
  task automatic serve(input bit rearm, input int acc_dly, input bit req_always,
                       input logic [N-1:0] raise_at_done, input bit rand_raise, input bit drop_rdy);
    int         w, n_req, stall, len, dly;
    bit         ok;
    logic       req_v;
    logic [7:0] dat_v[N];
    w = cur_w;
    wait_offer(ok);
    if (!ok) return;
    len = int'(len_m[w]);
    dly = (acc_dly < 0) ? $urandom_range(0, 3) : acc_dly;
    if (drop_rdy) bus.src_rdy[w] = 1'b0;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      #1 check("offer_hold", bus.mac_rdy, 1);
    end
    bus.mac_acc = 1'b1;
    #1 check("src_acc", bus.src_acc, onehot(w));
    g_at_acc = int'(grant);
    pend[w]  = 1'b0;
    @(negedge clk);
    bus.mac_acc    = 1'b0;
    bus.src_rdy[w] = 1'b0;
    #1 check("mac_rdy_low", bus.mac_rdy, 0);
    check("busy_active", busy, 1);
    n_req = 0;
    stall = 0;
    while (n_req < len) begin
      req_v = req_always || stall >= 20 || ($urandom_range(0, 3) != 0);
      bus.mac_req = req_v;
      for (int s = 0; s < N; s++) begin
        dat_v[s] = 8'($urandom());
        bus.src_dat[s] = dat_v[s];
      end
      #1 check("mac_dat", bus.mac_dat, dat_v[w]);
      check("src_req", bus.src_req, req_v ? onehot(w) : {N{1'b0}});
      if (req_v) n_req++;
      else stall++;
      @(negedge clk);
    end
    bus.mac_req  = 1'b0;
    bus.mac_done = 1'b1;
    if (rearm) raise(w, 0);
    for (int s = 0; s < N; s++) if (raise_at_done[s] && !pend[s]) raise(s, 0);
    if (rand_raise) begin
      for (int s = 0; s < N; s++) if (!pend[s] && $urandom_range(0, 2) == 0) raise(s, 0);
    end
    #1 check("src_done", bus.src_done, onehot(w));
    check("grant_at_done", grant, w);
    ptr_m = (w + 1) % N;
    if (pend != 0) push_expect(cyc + 2 + GAP_CYC);
    @(negedge clk);
    bus.mac_done = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic rdy_q = 1'b0;
  always @(negedge clk) begin
    offer_t e;
    #3;
    if (rst_n && bus.mac_rdy && !rdy_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_offer", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("offer_time", cyc, e.at);
        check("offer_grant", grant, e.g);
        check("offer_len", bus.mac_len, e.len);
        check("offer_dst", bus.mac_dst, e.dst);
        check("offer_etype", bus.mac_etype, e.etype);
      end
    end
    rdy_q = rst_n && bus.mac_rdy;
  end

  // ---------------- stimulus ----------------
  initial begin
    int  o, t, guard;
    bit  ok, seen_done;
    int  exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    bus.src_rdy  = '0;
    bus.src_dat  = '0;
    bus.mac_acc  = 1'b0;
    bus.mac_req  = 1'b0;
    bus.mac_done = 1'b0;
    for (int s = 0; s < N; s++) load_src(s, 0);

    // Reset state
    repeat (3) @(negedge clk);
    #1 check("rst_mac_rdy", bus.mac_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_err_tmo", err_tmo, 0);
    check("rst_state", state_dbg, 0);
    check("rst_src_strobes", {bus.src_acc, bus.src_req, bus.src_done}, 0);
    check("rst_mac_etype", bus.mac_etype, et_m[0]);
    check("rst_mac_dst", bus.mac_dst, dst_m[0]);
    @(negedge clk);
    rst_n = 1'b1;

    // All four sources requesting continuously from reset
    @(negedge clk);
    idle_raise('1, 0);
    for (int i = 0; i < 5; i++) begin
      serve(1, -1, 0, '0, 0, 0);
      check("rr_seq", g_at_acc, exp_seq[i]);
    end
    guard = 0;
    while (pend != 0 && guard < 10) begin
      serve(0, -1, 0, '0, 0, 0);
      guard++;
    end

    // Single source 2, 60-byte payload; source 0 queued at done to time the restart
    idle_wait();
    idle_raise(onehot(2), 60);
    serve(0, 0, 1, onehot(0), 0, 0);
    serve(0, -1, 0, '0, 0, 0);

    // Source 1 withdraws src_rdy while its offer is pending
    idle_wait();
    idle_raise(onehot(1), 0);
    serve(0, 3, 0, '0, 0, 1);

    // Randomized traffic
    for (int f = 0; f < 16; f++) begin
      if (pend == 0) begin
        idle_wait();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        idle_raise(4'($urandom_range(1, 15)), 0);
      end
      serve(0, -1, 0, '0, 1, 0);
    end
    guard = 0;
    while (pend != 0 && guard < 10) begin
      serve(0, -1, 0, '0, 0, 0);
      guard++;
    end

    // Watchdog: MAC accepts but never finishes
    idle_wait();
    idle_raise(onehot(1) | onehot(3), 0);
    wait_offer(ok);
    if (ok) begin
      o = cyc;
      bus.mac_acc = 1'b1;
      #1 check("tmo_src_acc", bus.src_acc, onehot(cur_w));
      pend[cur_w] = 1'b0;
      @(negedge clk);
      bus.mac_acc = 1'b0;
      bus.src_rdy[cur_w] = 1'b0;
      t = 0;
      seen_done = 0;
      #1;
      while (!err_tmo && t < 200) begin
        if (bus.src_done != 0) seen_done = 1;
        @(negedge clk);
        #1;
        t++;
      end
      check("tmo_time", cyc, o + TIMEOUT - 1);
      check("tmo_no_done", seen_done, 0);
      ptr_m = (cur_w + 1) % N;
      if (pend != 0) push_expect(cyc + 2);
      @(negedge clk);
      #1 check("tmo_pulse_len", err_tmo, 0);
      check("tmo_idle", busy, 0);
      serve(0, -1, 0, '0, 0, 0);
    end

    // Reset in the middle of a frame
    idle_wait();
    idle_raise(onehot(3), 0);
    wait_offer(ok);
    if (ok) begin
      bus.mac_acc = 1'b1;
      pend[cur_w] = 1'b0;
      @(negedge clk);
      bus.mac_acc = 1'b0;
      repeat (2) @(negedge clk);
      bus.mac_req = 1'b1;
      #1 check("pre_rst_src_req", bus.src_req, onehot(3));
      #1 rst_n = 1'b0;
      #1 check("arst_mac_rdy", bus.mac_rdy, 0);
      check("arst_busy", busy, 0);
      check("arst_src_strobes", {bus.src_acc, bus.src_req, bus.src_done}, 0);
      check("arst_grant", grant, 0);
      bus.mac_req = 1'b0;
      bus.src_rdy = '0;
      pend  = '0;
      ptr_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_raise('1, 0);
      for (int i = 0; i < N; i++) serve(0, -1, 0, '0, 0, 0);
    end

    // Final report
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "global timeout");
  end
endmodule
